// File: rtl/data_mem_pkg.sv
// Shared types and address decode for the data_mem_bram word memory.
// Build option: DATA_MEM_GRUBBY_EN enables per-lane grubby (poison) storage.
package data_mem_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = ST_CLEAR,
    RUN   = ST_RUN
  } state_t;

  // Returns {in_range, word_index}; an address below base wraps high and falls out of range.
  function automatic logic [30:0] mem_decode(input logic [31:0] addr,
                                             input int unsigned words,
                                             input logic [31:0] base);
    logic [31:0] off;
    logic [33:0] lim;
    off = addr - base;
    lim = 34'(words) << 2;
    return {({2'b00, off} < lim), off[31:2]};
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// One byte lane of the data memory: WORDS x (8 data + optional grubby bit), registered read port.
// Build option: DATA_MEM_GRUBBY_EN keeps the grubby bit array; otherwise rgrubby is tied low.
module data_mem_lane
  import data_mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              rzero,
  input  logic [AW-1:0]     addr,
  input  logic [LANE_W-1:0] wdata,
  input  logic              wgrubby,
  output logic [LANE_W-1:0] rdata,
  output logic              rgrubby
);

  logic [LANE_W-1:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)      rdata <= '0;
    else if (re)    rdata <= mem[addr];
    else if (rzero) rdata <= '0;
  end

`ifdef DATA_MEM_GRUBBY_EN
  logic gmem [WORDS];

  always_ff @(posedge clock) begin
    if (we) gmem[addr] <= wgrubby;
  end

  always_ff @(posedge clock) begin
    if (reset)      rgrubby <= 1'b0;
    else if (re)    rgrubby <= gmem[addr];
    else if (rzero) rgrubby <= 1'b0;
  end
`else
  assign rgrubby = 1'b0;
`endif

endmodule

// File: rtl/data_mem_bram.sv
// Word-organised data memory with one-cycle read latency, post-reset array clear and bench counters.
// Build option: DATA_MEM_GRUBBY_EN enables grubby tag storage and mem_rgrubby.
module data_mem_bram
  import data_mem_pkg::*;
#(
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wgrubby,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        mem_rgrubby,
  output logic        core_hold,
  output logic        err_range,
  output logic        err_early,
  output logic [31:0] cnt_rd,
  output logic [31:0] cnt_wr
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [30:0]   dec;
  logic          in_range;
  logic [AW-1:0] acc_idx;
  logic          running;
  logic          acc_wr;
  logic          acc_rd;
  logic          oor_rd;
  logic [AW-1:0] lane_addr;
  logic [LANES-1:0]  lane_we;
  logic [LANES-1:0]  lane_rg;
  logic [LANE_W-1:0] lane_rdata [LANES];

  assign dec      = mem_decode(mem_addr, WORDS, BASE_ADDR);
  assign in_range = dec[30];
  assign acc_idx  = AW'(dec[29:0]);
  assign running  = (state == RUN);
  assign acc_wr   = mem_valid && running && in_range && mem_write;
  assign acc_rd   = mem_valid && running && in_range && !mem_write;
  assign oor_rd   = mem_valid && running && !in_range && !mem_write;

  // During CLEAR the array port is taken over by the clear index and forced-zero data.
  assign lane_addr = running ? acc_idx : clr_idx;

  always_comb begin
    lane_we = '0;
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_we[i] = running ? (acc_wr && mem_wmask[i]) : 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    data_mem_lane #(
      .WORDS (WORDS),
      .AW    (AW)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .we      (lane_we[g]),
      .re      (acc_rd && !reset),
      .rzero   (oor_rd),
      .addr    (lane_addr),
      .wdata   (running ? mem_wdata[g*LANE_W +: LANE_W] : '0),
      .wgrubby (running && mem_wgrubby),
      .rdata   (lane_rdata[g]),
      .rgrubby (lane_rg[g])
    );
  end

  always_comb begin
    mem_rdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mem_rdata[i*LANE_W +: LANE_W] = lane_rdata[i];
    end
  end

  assign mem_rgrubby = |lane_rg;
  assign core_hold   = (state == CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      err_range <= 1'b0;
      err_early <= 1'b0;
      cnt_rd    <= '0;
      cnt_wr    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(WORDS - 1)) state <= RUN;
          if (mem_valid) err_early <= 1'b1;
        end
        RUN: begin
          if (mem_valid && !in_range) err_range <= 1'b1;
          if (acc_wr) cnt_wr <= cnt_wr + 32'd1;
          if (acc_rd) cnt_rd <= cnt_rd + 32'd1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
